mean_square: RTL and testbench

Frame-based mean-square accumulator that sits directly upstream of the fixed-point square-root stage; together they form the RMS path. It accepts a stream of 2^LOG2_N signed Q16.16 samples, squares and accumulates them, and divides by the frame length. It then presents the mean square as a held-stable 32-bit Q16.16 operand until the downstream stage acknowledges completion. Holding the operand stable is mandatory because the downstream square root restarts its iteration whenever its operand changes.

---
 rtl/mean_square_pkg.sv | 23 ++
 rtl/q_square.sv | 44 ++++
 rtl/mean_square.sv | 112 +++++++++++
 tb/tb_mean_square.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mean_square_pkg.sv
// mean_square_pkg: shared Q16.16 format constants, FSM state encodings and a
// magnitude helper for the RMS path (mean_square + q_square).
// No ports; imported by mean_square and q_square.
package mean_square_pkg;

  localparam int          Q_WIDTH  = 32;
  localparam int          Q_FRAC   = 16;
  localparam logic [31:0] Q_MAX    = 32'h7FFF_FFFF;
  localparam int          SQ_WIDTH = 48;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Two's-complement magnitude as unsigned; 0x80000000 yields 2^31, which
  // is exactly representable in 32 unsigned bits.
  function automatic logic [Q_WIDTH-1:0] abs_q(input logic [Q_WIDTH-1:0] a);
    return a[Q_WIDTH-1] ? (~a + 32'd1) : a;
  endfunction

endpackage

// File: rtl/q_square.sv
// q_square: registered square of a signed Q16.16 sample, rescaled to Q.FRAC.
// Ports: clk, rst_n (async active-low), en (load), a[31:0] signed sample,
//        sq[47:0] unsigned squared value, one cycle after en.
// Build option MEAN_SQUARE_ROUND_EN: round-half-up on the FRAC shift.
module q_square
  import mean_square_pkg::*;
#(
  parameter int FRAC = Q_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [Q_WIDTH-1:0]  a,
  output logic [SQ_WIDTH-1:0] sq
);

  logic [Q_WIDTH-1:0] w_abs;
  logic [63:0]        w_prod;
  logic [63:0]        w_rnd;
  logic [63:0]        w_shift;
  logic [15:0]        w_unused_hi;

  assign w_abs  = abs_q(a);
  assign w_prod = {32'd0, w_abs} * {32'd0, w_abs};

`ifdef MEAN_SQUARE_ROUND_EN
  // Max product is 2^62, so adding half an LSB cannot carry out of 64 bits.
  assign w_rnd = w_prod + (64'd1 << (FRAC - 1));
`else
  assign w_rnd = w_prod;
`endif

  assign w_shift     = w_rnd >> FRAC;
  assign w_unused_hi = w_shift[63:48];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq <= '0;
    end else if (en) begin
      sq <= w_shift[SQ_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mean_square.sv
// mean_square: frame mean square of 2^LOG2_N signed Q16.16 samples, held
// stable as an unsigned Q16.16 operand until the consumer acknowledges.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data sample
//        stream; out_valid/out_data result, out_ack consumer done; busy.
// Build option MEAN_SQUARE_ROUND_EN: round-half-up on both shifts.
module mean_square
  import mean_square_pkg::*;
#(
  parameter int LOG2_N = 4,
  parameter int FRAC   = Q_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [Q_WIDTH-1:0] out_data,
  input  logic               out_ack,
  output logic               busy
);

  localparam int                ACC_W    = SQ_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;
`ifdef MEAN_SQUARE_ROUND_EN
  localparam logic [ACC_W:0]    DIV_HALF = (ACC_W + 1)'(1) << (LOG2_N - 1);
`else
  localparam logic [ACC_W:0]    DIV_HALF = '0;
`endif

  state_t              r_state;
  logic [LOG2_N-1:0]   r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic                r_sq_vld;
  logic [Q_WIDTH-1:0]  r_out_dat;
  logic                r_out_vld;

  logic                w_accept;
  logic [SQ_WIDTH-1:0] w_sq;
  logic [ACC_W:0]      w_acc_rnd;
  logic [ACC_W:0]      w_mean;
  logic [Q_WIDTH-1:0]  w_res;

  assign in_ready  = (r_state == ST_ACC);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  // The square register still holding an unaccumulated product counts as
  // an undrained pipeline.
  assign busy      = (r_state != ST_ACC) | (r_cnt != '0) | r_sq_vld;

  q_square #(.FRAC(FRAC)) u_sq (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_accept),
    .a     (in_data),
    .sq    (w_sq)
  );

  // Extra top bit keeps the rounding add from wrapping.
  assign w_acc_rnd = {1'b0, r_acc} + DIV_HALF;
  assign w_mean    = w_acc_rnd >> LOG2_N;
  assign w_res     = (|w_mean[ACC_W:31]) ? Q_MAX : {1'b0, w_mean[30:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACC;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sq_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_sq_vld <= w_accept;
      if (r_sq_vld) begin
        r_acc <= r_acc + ACC_W'(w_sq);
      end

      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        // Wait until the last product has been folded into r_acc before
        // sampling the quotient.
        ST_DRAIN: begin
          if (!r_sq_vld) begin
            r_state   <= ST_HOLD;
            r_out_vld <= 1'b1;
            r_out_dat <= w_res;
          end
        end
        ST_HOLD: begin
          if (out_ack) begin
            r_state   <= ST_ACC;
            r_out_vld <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
          end
        end
        default: begin
          r_state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mean_square.sv
// tb_mean_square: directed checks of mean_square with LOG2_N=2 (4-sample frames).
module tb_mean_square;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ack  = 1'b0;
  logic [31:0] in_data  = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] out_data;

  int checks = 0;
  int passes = 0;

  mean_square #(.LOG2_N(2), .FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Feeds four samples back to back, then checks the k+1 / k+2 timing and the
  // held result. With ack_now the consumer acknowledges in the same cycle
  // out_valid rises, so out_valid must be high for exactly one cycle.
  task automatic run_frame(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3,
                           input logic [31:0] exp, input bit ack_now);
    logic [31:0] smp [4];
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = smp[i];
      chk({tag, "_rdy_acc"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_rdy_k"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_vld_k"},  {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld_k1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld_k2"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_dat"},    out_data,           exp);
    chk({tag, "_busy_h"}, {31'd0, busy},      32'd1);
    if (ack_now) begin
      out_ack = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      chk({tag, "_vld_off"},  {31'd0, out_valid}, 32'd0);
      chk({tag, "_busy_off"}, {31'd0, busy},      32'd0);
      chk({tag, "_rdy_off"},  {31'd0, in_ready},  32'd1);
      chk({tag, "_dat_keep"}, out_data,           exp);
    end
  endtask

  logic [31:0] rnd_exp;

  initial begin
    // Reset state.
    #12;
    chk("rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("rst_dat",  out_data,           32'd0);
    chk("rst_rdy",  {31'd0, in_ready},  32'd1);
    chk("rst_busy", {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1.0 squared, mean 1.0.
    run_frame("ones", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0001_0000, 1'b1);
    // +/-2.0 alternating, mean square 4.0.
    run_frame("pm2", 32'hFFFE_0000, 32'h0002_0000, 32'hFFFE_0000, 32'h0002_0000,
              32'h0004_0000, 1'b1);
    // Saturation on the largest positive and most negative samples.
    run_frame("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h7FFF_FFFF, 1'b1);
    run_frame("maxneg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
              32'h7FFF_FFFF, 1'b1);

    // 3.0 -> 9.0, then hold 10 cycles with in_valid pushing 5.0 samples.
    run_frame("hold", 32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000,
              32'h0009_0000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0005_0000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_rdy%0d", c), {31'd0, in_ready},  32'd0);
      chk($sformatf("hold_vld%0d", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold_dat%0d", c), out_data,           32'h0009_0000);
    end
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk("hold_ack_busy", {31'd0, busy},     32'd0);
    chk("hold_ack_rdy",  {31'd0, in_ready}, 32'd1);
    // Exactly four 5.0 samples must make up the next frame: 25.0.
    run_frame("after_hold", 32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000,
              32'h0019_0000, 1'b1);

    // 0xB6^2 = 33124, below one LSB after the FRAC shift unless rounded.
`ifdef MEAN_SQUARE_ROUND_EN
    rnd_exp = 32'h0000_0001;
`else
    rnd_exp = 32'h0000_0000;
`endif
    run_frame("round", 32'h0000_00B6, 32'h0000_00B6, 32'h0000_00B6, 32'h0000_00B6,
              rnd_exp, 1'b1);

    // Mid-frame reset discards two accepted 3.0 samples.
    run_frame("pre_rst", 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000,
              32'h0004_0000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h0003_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("mid_rst_dat",  out_data,           32'd0);
    chk("mid_rst_rdy",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_busy", {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame("post_rst", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0001_0000, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
